// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - time-multiplexed 7-segment scan driver with blink-in-set-mode
// Optional feature macro: SEG_SCAN_BLINK_EN (blink counter, phase and blanking).
module seg_scan #(
   parameter int DIGITS      = 6,
   parameter int SCAN_DIV    = 50000,
   parameter int GUARD       = 2,
   parameter int BLINK_TICKS = 500
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   bcd,
   input  logic [3:0]            mode,
   input  logic [DIGITS-1:0]     blink_sel,
   input  logic [DIGITS-1:0]     dp_mask,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PMAX   = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PGUARD = PW'(GUARD);
   localparam logic [IW-1:0] IMAX   = IW'(DIGITS - 1);

   logic [PW-1:0] pcnt;
   logic          tick;
   logic [IW-1:0] idx;
   logic [IW-1:0] nidx;
   logic [3:0]    dig;
   logic          ldp;
   logic          blank;
   logic [6:0]    pat;

   assign tick = (pcnt == PMAX);
   assign nidx = (idx == IMAX) ? '0 : idx + 1'b1;

   // Prescaler, slot index and the per-slot digit latch; the latch loads the
   // upcoming slot's data so it stays frozen for the whole slot.
   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         pcnt <= '0;
         idx  <= '0;
         dig  <= '0;
         ldp  <= 1'b0;
      end else if (tick) begin
         pcnt <= '0;
         idx  <= nidx;
         dig  <= bcd[4*nidx +: 4];
         ldp  <= dp_mask[nidx];
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [BW-1:0] BMAX = BW'(BLINK_TICKS - 1);

   logic [BW-1:0] bcnt;
   logic          bph;
   logic          lblink;

   // Blink phase advances on slot ticks; phase starts visible after reset.
   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         bcnt   <= '0;
         bph    <= 1'b1;
         lblink <= 1'b0;
      end else if (tick) begin
         lblink <= blink_sel[nidx];
         if (bcnt == BMAX) begin
            bcnt <= '0;
            bph  <= ~bph;
         end else begin
            bcnt <= bcnt + 1'b1;
         end
      end
   end

   assign blank = (mode == 4'b0010) && lblink && !bph;
`else
   logic unused_blink;
   assign unused_blink = ^{mode, blink_sel};
   assign blank        = 1'b0;
`endif

   // Digit to active-low segment pattern; anything above 9 shows a dash.
   always_comb begin
      pat = 7'h3F;
      case (dig)
         4'd0: pat = 7'h40;
         4'd1: pat = 7'h79;
         4'd2: pat = 7'h24;
         4'd3: pat = 7'h30;
         4'd4: pat = 7'h19;
         4'd5: pat = 7'h12;
         4'd6: pat = 7'h02;
         4'd7: pat = 7'h78;
         4'd8: pat = 7'h00;
         4'd9: pat = 7'h10;
         default: pat = 7'h3F;
      endcase
   end

   // Single output register stage; anodes dark during the guard window,
   // blanked digits keep their anode so on-time stays uniform.
   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         an  <= '1;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= (pcnt < PGUARD) ? '1 : ~(DIGITS'(1) << idx);
         seg <= blank ? 7'h7F : pat;
         dp  <= blank | ~ldp;
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - randomized self-checking bench for seg_scan against a cycle-count model
module tb_seg_scan;

   localparam int D  = 6;
   localparam int SD = 4;
   localparam int G  = 1;
   localparam int BT = 3;
`ifdef SEG_SCAN_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic          clk;
   logic          en;
   logic [23:0]   bcd;
   logic [3:0]    mode;
   logic [5:0]    blink_sel;
   logic [5:0]    dp_mask;
   logic [5:0]    an;
   logic [6:0]    seg;
   logic          dp;

   int ntests = 0;
   int nfail  = 0;
   bit chk_on = 0;

   seg_scan #(.DIGITS(D), .SCAN_DIV(SD), .GUARD(G), .BLINK_TICKS(BT)) dut (
      .clk(clk), .en(en), .bcd(bcd), .mode(mode), .blink_sel(blink_sel),
      .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] dec(input logic [3:0] v);
      case (v)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   // Model: state after k edges since release is pcnt=k%SD, tick count k/SD,
   // slot (k/SD)%D, visible phase when (k/SD)/BT is even.
   int         k;
   int         m_pc, m_tk, m_id, m_nid;
   bit         m_vis, m_blank;
   logic [3:0] mdig;
   logic       mbl, mdp;
   logic [5:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp;

   always begin
      @(posedge clk or negedge en);
      if (!en) begin
         k = 0; mdig = 4'd0; mbl = 1'b0; mdp = 1'b0;
         e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         m_pc  = k % SD;
         m_tk  = k / SD;
         m_id  = m_tk % D;
         m_vis = ((m_tk / BT) % 2) == 0;
         e_an  = (m_pc < G) ? 6'h3F : ~(6'(1) << m_id);
         m_blank = BLINK && (mode == 4'b0010) && mbl && !m_vis;
         e_seg = m_blank ? 7'h7F : dec(mdig);
         e_dp  = m_blank ? 1'b1 : !mdp;
         if (m_pc == SD - 1) begin
            m_nid = (m_id + 1) % D;
            mdig  = bcd[4*m_nid +: 4];
            mbl   = blink_sel[m_nid];
            mdp   = dp_mask[m_nid];
         end
         k++;
      end
   end

   always begin
      @(negedge clk);
      if (chk_on) begin
         ntests++;
         if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
            nfail++;
            $display("FAIL model t=%0t an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     $time, an, seg, dp, e_an, e_seg, e_dp);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      ntests++;
      if (got !== want) begin
         nfail++;
         $display("FAIL %s got=%h required=%h", name, got, want);
      end
   endtask

   task automatic wait_an(input logic [5:0] target, input string name);
      int n;
      n = 0;
      while (an !== target && n < 64) begin
         @(negedge clk);
         n++;
      end
      ntests++;
      if (an !== target) begin
         nfail++;
         $display("FAIL %s timeout an=%h required=%h", name, an, target);
      end
   endtask

   task automatic rand_inputs();
      logic [3:0] modes [5];
      modes[0] = 4'b0001; modes[1] = 4'b0010; modes[2] = 4'b0100;
      modes[3] = 4'b1000; modes[4] = 4'b0010;
      bcd       = 24'($urandom);
      dp_mask   = 6'($urandom);
      blink_sel = 6'($urandom);
      mode      = modes[$urandom_range(0, 4)];
   endtask

   initial begin
      en = 1'b0;
      rand_inputs();
      @(negedge clk);
      chk_on = 1;
      for (int i = 0; i < 4; i++) begin
         rand_inputs();
         @(negedge clk);
         check("reset_an", 32'(an), 32'h3F);
         check("reset_seg", 32'(seg), 32'h7F);
         check("reset_dp", 32'(dp), 32'h1);
      end

      bcd = 24'h123456; dp_mask = 6'h00; blink_sel = 6'h00; mode = 4'b0001;
      en = 1'b1;
      @(negedge clk);
      check("release_guard_an", 32'(an), 32'h3F);
      @(negedge clk);
      check("release_first_an", 32'(an), 32'h3E);
      check("release_first_seg", 32'(seg), 32'h40);

      wait_an(6'h3D, "scan_slot1");
      check("scan_slot1_seg", 32'(seg), 32'h12);
      wait_an(6'h1F, "scan_slot5");
      check("scan_slot5_seg", 32'(seg), 32'h79);
      wait_an(6'h3E, "scan_wrap0");
      check("scan_wrap0_seg", 32'(seg), 32'h02);

      bcd = 24'h123B56; dp_mask = 6'b000100;
      wait_an(6'h3D, "oor_pre");
      wait_an(6'h3B, "oor_slot2");
      check("oor_seg", 32'(seg), 32'h3F);
      check("oor_dp_on", 32'(dp), 32'h0);
      wait_an(6'h37, "oor_slot3");
      check("oor_dp_off", 32'(dp), 32'h1);

      bcd[15:12] = 4'd9;
      @(negedge clk);
      check("midslot_hold_a", 32'(seg), 32'h30);
      @(negedge clk);
      check("midslot_hold_b", 32'(seg), 32'h30);
      wait_an(6'h3E, "midslot_wrap");
      wait_an(6'h37, "midslot_revisit");
      check("midslot_new", 32'(seg), 32'h10);

      bcd = 24'h123456; dp_mask = 6'h00; blink_sel = 6'b001000; mode = 4'b0010;
      wait_an(6'h3E, "blink_wrap");
      wait_an(6'h37, "blink_slot3");
      check("blink_set_seg", 32'(seg), BLINK ? 32'h7F : 32'h30);
      mode = 4'b0001;
      wait_an(6'h3E, "noblink_wrap");
      wait_an(6'h37, "noblink_slot3");
      check("noblink_seg", 32'(seg), 32'h30);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) rand_inputs();
         @(negedge clk);
      end

      mode = 4'b0001;
      wait_an(6'h37, "async_lit");
      @(posedge clk);
      #2;
      check("async_pre_an", 32'(an), 32'h37);
      en = 1'b0;
      #1;
      check("async_an", 32'(an), 32'h3F);
      check("async_seg", 32'(seg), 32'h7F);
      check("async_dp", 32'(dp), 32'h1);
      repeat (3) @(negedge clk);
      en = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) rand_inputs();
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
